// File: rtl/mmcm_phase_stepper.sv
// mmcm_phase_stepper: issues MMCM fine phase steps over psen/psdone.
// Optional psdone watchdog built when PS_TIMEOUT_EN is defined.
module mmcm_phase_stepper #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic        lb_clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] step_count,
  input  logic        abort,
  input  logic        mmcm_locked,
  input  logic        psdone,
  output logic        psen,
  output logic        psincdec,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        timeout,
  output logic        aborted,
  output logic [15:0] position,
  output logic [15:0] remaining
);

  typedef enum logic [1:0] {
    S_IDLE, S_PULSE, S_WAIT, S_SETTLE
  } state_t;

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t      state_q, state_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] pos_q, pos_d;
  logic [15:0] mag;
  logic        dir_q, dir_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        abt_q, abt_d;
  logic        apend_q, apend_d;
  logic        stop;
  logic [SW-1:0] scnt_q, scnt_d;

`ifdef PS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic          tmo_q, tmo_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
`endif

  // -32768 maps to 32768, which still fits the unsigned count
  assign mag  = step_count[15] ? (~step_count + 16'd1) : step_count;
  assign stop = apend_q | abort;

  // next state and datapath; lock loss overrides everything
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    err_d   = err_q;
    abt_d   = abt_q;
    apend_d = apend_q;
    scnt_d  = scnt_q;
`ifdef PS_TIMEOUT_EN
    tmo_d   = tmo_q;
    tcnt_d  = '0;
`endif
    if (!mmcm_locked) begin
      pos_d = '0;
      if (state_q != S_IDLE) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
        rem_d   = '0;
      end else if (start) begin
        err_d = 1'b1;
      end
    end else begin
      if (state_q != S_IDLE && abort)
        apend_d = 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            rem_d = mag;
            dir_d = ~step_count[15];
            err_d = 1'b0;
            abt_d = 1'b0;
`ifdef PS_TIMEOUT_EN
            tmo_d = 1'b0;
`endif
            if (step_count == 16'd0)
              done_d = 1'b1;
            else
              state_d = S_PULSE;
          end
        end
        S_PULSE: state_d = S_WAIT;
        S_WAIT: begin
          if (psdone) begin
            pos_d = dir_q ? pos_q + 16'd1
                          : pos_q - 16'd1;
            rem_d = rem_q - 16'd1;
            if (rem_q == 16'd1 || stop) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
              abt_d   = stop && (rem_q != 16'd1);
            end else if (SETTLE == 0) begin
              state_d = S_PULSE;
            end else begin
              state_d = S_SETTLE;
              scnt_d  = '0;
            end
          end
`ifdef PS_TIMEOUT_EN
          else if (tcnt_q == TW'(TIMEOUT - 1)) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            tmo_d   = 1'b1;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
`endif
        end
        S_SETTLE: begin
          if (scnt_q == SW'(SETTLE - 1)) begin
            if (stop) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
              abt_d   = 1'b1;
            end else begin
              state_d = S_PULSE;
            end
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (state_d == S_IDLE)
      apend_d = 1'b0;
  end

  // state and datapath registers
  always_ff @(posedge lb_clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      pos_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      abt_q   <= 1'b0;
      apend_q <= 1'b0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      err_q   <= err_d;
      abt_q   <= abt_d;
      apend_q <= apend_d;
      scnt_q  <= scnt_d;
    end
  end

`ifdef PS_TIMEOUT_EN
  // psdone watchdog registers
  always_ff @(posedge lb_clk or posedge rst) begin
    if (rst) begin
      tmo_q  <= 1'b0;
      tcnt_q <= '0;
    end else begin
      tmo_q  <= tmo_d;
      tcnt_q <= tcnt_d;
    end
  end
  assign timeout = tmo_q;
`else
  // tied low: no watchdog in this build
  assign timeout = (TIMEOUT < 0);
`endif

  // outputs decoded from state
  always_comb begin
    psen = (state_q == S_PULSE) && mmcm_locked;
    busy = (state_q != S_IDLE);
  end

  assign psincdec  = dir_q;
  assign done      = done_q;
  assign error     = err_q;
  assign aborted   = abt_q;
  assign position  = pos_q;
  assign remaining = rem_q;

endmodule

// File: tb/tb_mmcm_phase_stepper.sv
// tb_mmcm_phase_stepper: randomized moves against a step-count model.
// Second instance (SETTLE=0) exercises the position wrap.
module tb_mmcm_phase_stepper;
  localparam int ST = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start = 1'b0, abort = 1'b0;
  logic        locked = 1'b1;
  logic        rsp_done = 1'b0, inj_done = 1'b0;
  logic        psdone;
  logic [15:0] step_count = '0;
  logic        psen, psincdec, busy, done;
  logic        error, timeout, aborted;
  logic [15:0] position, remaining;

  assign psdone = rsp_done | inj_done;

  mmcm_phase_stepper #(.SETTLE(ST), .TIMEOUT(1023)) dut (
    .lb_clk(clk), .rst(rst), .start(start),
    .step_count(step_count), .abort(abort),
    .mmcm_locked(locked), .psdone(psdone),
    .psen(psen), .psincdec(psincdec), .busy(busy),
    .done(done), .error(error), .timeout(timeout),
    .aborted(aborted), .position(position),
    .remaining(remaining)
  );

  logic        start_w = 1'b0, abort_w = 1'b0;
  logic        locked_w = 1'b1;
  logic        psdone_w = 1'b0, pend_w = 1'b0;
  logic [15:0] step_w = '0;
  logic        psen_w, psincdec_w, busy_w, done_w;
  logic        error_w, timeout_w, aborted_w;
  logic [15:0] position_w, remaining_w;

  mmcm_phase_stepper #(.SETTLE(0), .TIMEOUT(1023)) dutw (
    .lb_clk(clk), .rst(rst), .start(start_w),
    .step_count(step_w), .abort(abort_w),
    .mmcm_locked(locked_w), .psdone(psdone_w),
    .psen(psen_w), .psincdec(psincdec_w),
    .busy(busy_w), .done(done_w), .error(error_w),
    .timeout(timeout_w), .aborted(aborted_w),
    .position(position_w), .remaining(remaining_w)
  );

  int checks = 0, errors = 0;
  int lat = 1, cd = 0, cyc = 0;
  bit rsp_en = 1'b1;
  int psen_cnt = 0, done_cnt = 0, dir_bad = 0;
  int min_gap = 1 << 30, last_psen = -1;
  bit exp_dir = 1'b1;
  int done_cnt_w = 0, dir_bad_w = 0;
  bit exp_dir_w = 1'b0;
  logic [15:0] mpos = '0;

  // MMCM responder and event counters for the main instance
  always @(negedge clk) begin
    cyc++;
    rsp_done = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) rsp_done = 1'b1;
    end
    if (psen && rsp_en) cd = lat;
    if (psen) begin
      psen_cnt++;
      if (psincdec !== exp_dir) dir_bad++;
      if (last_psen >= 0 && cyc - last_psen < min_gap)
        min_gap = cyc - last_psen;
      last_psen = cyc;
    end
    if (done) done_cnt++;
  end

  // one-cycle-latency responder for the wrap instance
  always @(negedge clk) begin
    psdone_w = pend_w;
    pend_w = psen_w;
    if (psen_w && psincdec_w !== exp_dir_w) dir_bad_w++;
    if (done_w) done_cnt_w++;
  end

  task automatic clear_stats();
    psen_cnt = 0; done_cnt = 0; dir_bad = 0;
    min_gap = 1 << 30; last_psen = -1;
  endtask

  task automatic kick(input logic [15:0] sc);
    @(negedge clk); step_count = sc; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_psen(input int n, output bit ok);
    int k = 0;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (psen) k++;
      if (k == n) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({psen, psincdec, busy, done, error, timeout, aborted} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0",
        {psen, psincdec, busy, done, error, timeout, aborted});
    end
    checks++;
    if (position !== 16'd0 || remaining !== 16'd0) begin
      errors++;
      $display("FAIL reset_regs: got pos %0d rem %0d want 0 0",
        position, remaining);
    end
    rst = 1'b0;
    clear_stats(); lat = 12; exp_dir = 1'b1;
    kick(16'd3);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || remaining !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: got busy %b rem %0d want 0 0",
        busy, remaining);
    end
    @(negedge clk); rst = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_forward();
    bit ok;
    clear_stats(); lat = 12; exp_dir = 1'b1;
    kick(16'd3);
    wait_idle(500, ok);
    mpos = mpos + 16'd3;
    checks++;
    if (!ok) begin errors++; $display("FAIL fwd_idle: got busy want idle"); end
    checks++;
    if (psen_cnt !== 3) begin
      errors++; $display("FAIL fwd_psen: got %0d want 3", psen_cnt);
    end
    checks++;
    if (position !== mpos || remaining !== 16'd0) begin
      errors++;
      $display("FAIL fwd_pos: got %0d/%0d want %0d/0", position, remaining, mpos);
    end
    checks++;
    if (done_cnt !== 1 || dir_bad !== 0) begin
      errors++;
      $display("FAIL fwd_done_dir: got %0d/%0d want 1/0", done_cnt, dir_bad);
    end
    checks++;
    if (min_gap !== lat + ST + 1) begin
      errors++;
      $display("FAIL fwd_gap: got %0d want %0d", min_gap, lat + ST + 1);
    end
  endtask

  task automatic test_zero_busy();
    bit ok;
    clear_stats();
    kick(16'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: got done %b busy %b want 1 0", done, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || psen_cnt !== 0) begin
      errors++;
      $display("FAIL zero_pulse: got done %b psen %0d want 0 0", done, psen_cnt);
    end
    clear_stats(); lat = $urandom_range(2, 6); exp_dir = 1'b1;
    kick(16'd2);
    repeat (3) @(negedge clk);
    kick(16'd5);
    wait_idle(500, ok);
    mpos = mpos + 16'd2;
    checks++;
    if (!ok || psen_cnt !== 2 || done_cnt !== 1) begin
      errors++;
      $display("FAIL busy_start: got psen %0d done %0d want 2 1", psen_cnt, done_cnt);
    end
    checks++;
    if (position !== mpos) begin
      errors++; $display("FAIL busy_pos: got %0d want %0d", position, mpos);
    end
  endtask

  task automatic test_abort();
    bit ok;
    clear_stats(); lat = $urandom_range(3, 8); exp_dir = 1'b1;
    kick(16'd10);
    wait_psen(4, ok);
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    wait_idle(500, ok);
    mpos = mpos + 16'd4;
    checks++;
    if (psen_cnt !== 4 || done_cnt !== 1) begin
      errors++;
      $display("FAIL abort_cnt: got psen %0d done %0d want 4 1", psen_cnt, done_cnt);
    end
    checks++;
    if (position !== mpos || remaining !== 16'd6) begin
      errors++;
      $display("FAIL abort_pos: got %0d/%0d want %0d/6", position, remaining, mpos);
    end
    checks++;
    if (aborted !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL abort_flag: got %b%b want 10", aborted, error);
    end
  endtask

  task automatic test_abort_simul();
    bit ok;
    clear_stats(); lat = 5; exp_dir = 1'b1;
    kick(16'd6);
    wait_psen(2, ok);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    wait_idle(500, ok);
    mpos = mpos + 16'd2;
    checks++;
    if (position !== mpos || remaining !== 16'd4 || aborted !== 1'b1) begin
      errors++;
      $display("FAIL abort_simul: got %0d/%0d/%b want %0d/4/1",
        position, remaining, aborted, mpos);
    end
    checks++;
    if (psen_cnt !== 2 || done_cnt !== 1) begin
      errors++;
      $display("FAIL abort_simul_cnt: got %0d/%0d want 2/1", psen_cnt, done_cnt);
    end
  endtask

  task automatic test_abort_idle();
    bit ok;
    clear_stats(); lat = $urandom_range(1, 5); exp_dir = 1'b1;
    kick(16'd1);
    wait_idle(200, ok);
    mpos = mpos + 16'd1;
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (aborted !== 1'b0 || busy !== 1'b0 || position !== mpos) begin
      errors++;
      $display("FAIL abort_idle: got %b%b pos %0d want 00 pos %0d",
        aborted, busy, position, mpos);
    end
  endtask

  task automatic test_random();
    bit ok;
    int sc, n;
    for (int m = 0; m < 8; m++) begin
      sc = int'($urandom_range(0, 14)) - 7;
      n = (sc < 0) ? -sc : sc;
      clear_stats(); lat = $urandom_range(1, 9);
      exp_dir = (sc >= 0);
      kick(16'(sc));
      wait_idle(500, ok);
      mpos = mpos + 16'(sc);
      checks++;
      if (!ok || psen_cnt !== n || dir_bad !== 0) begin
        errors++;
        $display("FAIL rnd_psen: got %0d (dir bad %0d) want %0d", psen_cnt, dir_bad, n);
      end
      checks++;
      if (position !== mpos || remaining !== 16'd0 || done_cnt !== 1) begin
        errors++;
        $display("FAIL rnd_pos: got %0d/%0d/%0d want %0d/0/1",
          position, remaining, done_cnt, mpos);
      end
      if (n >= 2) begin
        checks++;
        if (min_gap !== lat + ST + 1) begin
          errors++;
          $display("FAIL rnd_gap: got %0d want %0d", min_gap, lat + ST + 1);
        end
      end
    end
  endtask

  task automatic test_spurious();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); inj_done = 1'b1;
      @(negedge clk); inj_done = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (position !== mpos || busy !== 1'b0) begin
      errors++;
      $display("FAIL spurious: got %0d want %0d", position, mpos);
    end
  endtask

  task automatic test_lock_loss();
    bit ok;
    clear_stats(); lat = 2; exp_dir = 1'b1;
    kick(16'd6);
    wait_psen(2, ok);
    repeat (3) @(negedge clk);
    locked = 1'b0;
    @(negedge clk);
    mpos = '0;
    checks++;
    if (busy !== 1'b0 || error !== 1'b1) begin
      errors++;
      $display("FAIL lock_state: got busy %b err %b want 0 1", busy, error);
    end
    checks++;
    if (position !== 16'd0 || remaining !== 16'd0) begin
      errors++;
      $display("FAIL lock_regs: got %0d/%0d want 0/0", position, remaining);
    end
    repeat (20) @(negedge clk);
    locked = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (psen_cnt !== 2 || done_cnt !== 0) begin
      errors++;
      $display("FAIL lock_cnt: got %0d/%0d want 2/0", psen_cnt, done_cnt);
    end
    clear_stats(); lat = 4;
    kick(16'd3);
    wait_psen(2, ok);
    repeat (4) @(negedge clk);
    locked = 1'b0;
    @(negedge clk);
    checks++;
    if (position !== 16'd0 || busy !== 1'b0 || done_cnt !== 0) begin
      errors++;
      $display("FAIL lock_psdone: got pos %0d busy %b done %0d want 0 0 0",
        position, busy, done_cnt);
    end
    clear_stats();
    kick(16'd3);
    repeat (5) @(negedge clk);
    checks++;
    if (psen_cnt !== 0 || done_cnt !== 0 || error !== 1'b1) begin
      errors++;
      $display("FAIL unlocked_start: got %0d/%0d/%b want 0/0/1",
        psen_cnt, done_cnt, error);
    end
    locked = 1'b1;
    repeat (2) @(negedge clk);
    kick(16'd0);
    checks++;
    if (error !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL err_clear: got err %b done %b want 0 1", error, done);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    clear_stats(); rsp_en = 1'b0; exp_dir = 1'b1;
    kick(16'd1);
`ifdef PS_TIMEOUT_EN
    n = 0;
    while (busy && n < 2000) begin @(negedge clk); n++; end
    checks++;
    if (n !== 1024) begin
      errors++; $display("FAIL tmo_len: got %0d want 1024", n);
    end
    checks++;
    if (timeout !== 1'b1 || error !== 1'b1 || position !== mpos) begin
      errors++;
      $display("FAIL tmo_flags: got %b%b pos %0d want 11 pos %0d",
        timeout, error, position, mpos);
    end
    @(negedge clk);
    checks++;
    if (done_cnt !== 0) begin
      errors++; $display("FAIL tmo_done: got %0d want 0", done_cnt);
    end
    rsp_en = 1'b1;
    kick(16'd0);
    checks++;
    if (timeout !== 1'b0 || error !== 1'b0) begin
      errors++; $display("FAIL tmo_clear: got %b%b want 00", timeout, error);
    end
`else
    n = 0;
    repeat (5000) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL no_tmo: got busy %b tmo %b want 1 0", busy, timeout);
    end
    inj_done = 1'b1;
    @(negedge clk); inj_done = 1'b0;
    wait_idle(50, ok);
    mpos = mpos + 16'd1;
    rsp_en = 1'b1;
    checks++;
    if (!ok || done_cnt !== 1 || position !== mpos || n !== 0) begin
      errors++;
      $display("FAIL no_tmo_end: got done %0d pos %0d want 1 %0d",
        done_cnt, position, mpos);
    end
`endif
  endtask

  task automatic test_wrap();
    bit ok = 1'b0;
    exp_dir_w = 1'b0;
    @(negedge clk); step_w = 16'h8001; start_w = 1'b1;
    @(negedge clk); start_w = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk);
      if (!busy_w) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || position_w !== 16'h8001) begin
      errors++;
      $display("FAIL wrap_pre: got %0d want -32767", $signed(position_w));
    end
    @(negedge clk); step_w = 16'hFFFE; start_w = 1'b1;
    @(negedge clk); start_w = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy_w) begin ok = 1'b1; break; end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (!ok || position_w !== 16'h7FFF || psincdec_w !== 1'b0) begin
      errors++;
      $display("FAIL wrap: got %0d dir %b want 32767 dir 0",
        $signed(position_w), psincdec_w);
    end
    checks++;
    if (done_cnt_w !== 2 || dir_bad_w !== 0 || remaining_w !== 16'd0
        || {error_w, timeout_w, aborted_w} !== 3'b0) begin
      errors++;
      $display("FAIL wrap_misc: got done %0d dirbad %0d want 2 0",
        done_cnt_w, dir_bad_w);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_zero_busy();
    test_abort();
    test_abort_simul();
    test_abort_idle();
    test_random();
    test_spurious();
    test_lock_loss();
    test_timeout();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmcm_phase_stepper.md
MMCM_PHASE_STEPPER -- requirements
Module: mmcm_phase_stepper

Interface
REQ-001 Parameter SETTLE, default 4: idle lb_clk cycles inserted after each psdone before the next psen.
REQ-002 Parameter TIMEOUT, default 1023: maximum lb_clk cycles spent waiting for psdone (used only with PS_TIMEOUT_EN).
REQ-003 lb_clk  in  1  sole clock; all logic on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  single-cycle request to begin a move.
REQ-006 step_count  in  16  signed two's-complement step request, sampled on accepted start.
REQ-007 abort  in  1  single-cycle request to stop after the step in flight.
REQ-008 mmcm_locked  in  1  MMCM lock status.
REQ-009 psdone  in  1  MMCM phase-shift completion pulse.
REQ-010 psen  out  1  MMCM phase-shift enable, single-cycle.
REQ-011 psincdec  out  1  direction: 1 = increment (positive step_count).
REQ-012 busy  out  1  high in any state other than IDLE.
REQ-013 done  out  1  single-cycle move-complete pulse.
REQ-014 error  out  1  sticky fault flag.
REQ-015 timeout  out  1  sticky flag: psdone wait expired.
REQ-016 aborted  out  1  sticky flag: last move ended by abort.
REQ-017 position  out  16  signed accumulated phase steps since lock.
REQ-018 remaining  out  16  unsigned steps still to issue.

Function
REQ-019 States are IDLE, PULSE, WAIT_DONE and SETTLE.
REQ-020 start in IDLE with mmcm_locked=1 is accepted: remaining <= |step_count| (16-bit unsigned, -32768 -> 32768), psincdec <= ~step_count[15], and error/timeout/aborted clear.
REQ-021 Accepted start with step_count=0: stay IDLE, done pulses next cycle, no psen.
REQ-022 Accepted start with nonzero step_count: go to PULSE next cycle.
REQ-023 start in IDLE with mmcm_locked=0: error <= 1, no psen, no done.
REQ-024 start while busy is ignored.
REQ-025 PULSE: psen=1 for exactly that one cycle, then go to WAIT_DONE.
REQ-026 psincdec is held stable from acceptance through the end of the move.
REQ-027 WAIT_DONE, on psdone: position <= position ±1 (+1 if psincdec; 16-bit wrap, no saturation) and remaining <= remaining-1.
REQ-028 WAIT_DONE exit after psdone: if remaining becomes 0 or abort is pending, go to IDLE with a done pulse; otherwise go to SETTLE.
REQ-029 SETTLE lasts exactly SETTLE cycles, then goes to PULSE; SETTLE=0 goes directly to PULSE.
REQ-030 psen-to-psen spacing is therefore at least 2+SETTLE cycles plus the psdone latency.
REQ-031 psdone outside WAIT_DONE is ignored and does not change position.
REQ-032 abort while busy sets a pending flag; no new psen is issued.
REQ-033 With abort pending, a move in WAIT_DONE waits for psdone; PULSE or SETTLE completes the current step, then goes to IDLE.
REQ-034 On an aborted exit: done pulses, aborted <= 1, and remaining keeps the unissued count.
REQ-035 abort in IDLE has no effect.
REQ-036 mmcm_locked=0 in any busy state: go to IDLE next cycle, error <= 1, remaining <= 0, psen=0, no done pulse.
REQ-037 position <= 0 on every cycle mmcm_locked=0, including in IDLE.
REQ-038 Simultaneous psdone and lock loss: lock loss wins and position clears.
REQ-039 Simultaneous psdone and abort in WAIT_DONE: the step counts, then exit per REQ-034.

Reset
REQ-040 rst=1 forces IDLE asynchronously with psen=0, psincdec=0, busy=0, done=0, error=0, timeout=0, aborted=0, position=0, remaining=0, abort pending cleared, and all counters at 0.

Configuration
REQ-041 Macro PS_TIMEOUT_EN defined: a WAIT_DONE counter starts at 0 on entry.
REQ-042 With PS_TIMEOUT_EN, reaching TIMEOUT cycles without psdone: go to IDLE, timeout <= 1, error <= 1, position unchanged, no done pulse.
REQ-043 Macro PS_TIMEOUT_EN undefined: WAIT_DONE waits indefinitely, no counter logic exists, and timeout is constant 0.

Verification
REQ-044 Forward move: locked, step_count=+3, psdone 12 cycles after each psen -> exactly 3 psen pulses with psincdec=1, position 0->3, one done, remaining=0.
REQ-045 Reverse move and wrap: position=-32767, step_count=-2 -> psincdec=0, position ends at +32767 (wrap), done pulses.
REQ-046 Zero and busy start: step_count=0 -> done one cycle later with no psen; a second start(+5) during a +2 move is ignored, so total psen=2.
REQ-047 Abort: step_count=+10, abort asserted during the 4th WAIT_DONE -> 4 psen total, position=+4, remaining=6, aborted=1, one done.
REQ-048 Lock loss: drop mmcm_locked in SETTLE mid-move -> IDLE next cycle, error=1, position=0, no done, and no further psen.
REQ-049 PS_TIMEOUT_EN with TIMEOUT=1023: psdone withheld -> IDLE exactly 1023 cycles after WAIT_DONE entry, timeout=1=error; without the macro, busy stays high beyond 5000 cycles.
